// File: rtl/cmp_pkg.sv
// Shared definitions for the compare-result interface: one-hot result codes,
// serial comparator state and sticky-record encodings, and cascade resolution.
package cmp_pkg;

  localparam logic [2:0] CMP_GT  = 3'b100;
  localparam logic [2:0] CMP_LT  = 3'b010;
  localparam logic [2:0] CMP_EQ  = 3'b001;
  localparam logic [2:0] CMP_INV = 3'b000;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } stateT;

  // First recorded difference while scanning MSB first.
  typedef enum logic [1:0] {
    REC_NONE = 2'b00,
    REC_LT   = 2'b01,
    REC_GT   = 2'b10
  } recT;

  // Equal operands defer to the lower-order word; only a clean one-hot code passes.
  function automatic logic [2:0] resolveEq(input logic [2:0] cascade);
    logic [2:0] res;
    case (cascade)
      CMP_GT, CMP_LT, CMP_EQ: res = cascade;
      default:                res = CMP_INV;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/serial_cmp_cell.sv
// Single-bit compare step: updates the sticky first-difference record and
// flags when a new difference is recorded in this bit.
module serial_cmp_cell
  import cmp_pkg::*;
(
  input  logic       aBit,
  input  logic       bBit,
  input  logic [1:0] stickyIn,
  output logic [1:0] stickyOut,
  output logic       diff
);

  always_comb begin
    stickyOut = stickyIn;
    diff      = 1'b0;
    if (stickyIn == REC_NONE && aBit != bBit) begin
      diff      = 1'b1;
      stickyOut = aBit ? REC_GT : REC_LT;
    end
  end

endmodule

// File: rtl/serial_compare_fsm.sv
// Bit-serial unsigned magnitude comparator, MSB first, with cascade input and
// one-hot {A>B, A<B, A=B} result.
module serial_compare_fsm
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iValid,
  output logic             oReady,
  input  logic [WIDTH-1:0] iData_a,
  input  logic [WIDTH-1:0] iData_b,
  input  logic [2:0]       iCascade,
  output logic             oValid,
  output logic [2:0]       oData,
  output logic             oBusy
);

  localparam int unsigned CntW = $clog2(WIDTH);

  stateT            state;
  logic [WIDTH-1:0] aReg;
  logic [WIDTH-1:0] bReg;
  logic [CntW-1:0]  cnt;
  logic [2:0]       cascadeReg;
  logic [1:0]       sticky;
  logic [1:0]       stickyNext;
  logic             diff;

  serial_cmp_cell uCell (
    .aBit      (aReg[WIDTH-1]),
    .bBit      (bReg[WIDTH-1]),
    .stickyIn  (sticky),
    .stickyOut (stickyNext),
    .diff      (diff)
  );

  assign oReady = (state == IDLE);
  assign oBusy  = (state != IDLE);

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state      <= IDLE;
      aReg       <= '0;
      bReg       <= '0;
      cnt        <= '0;
      cascadeReg <= CMP_INV;
      sticky     <= REC_NONE;
      oValid     <= 1'b0;
      oData      <= CMP_INV;
    end else begin
      oValid <= 1'b0;
      case (state)
        IDLE: begin
          if (iValid) begin
            aReg       <= iData_a;
            bReg       <= iData_b;
            cascadeReg <= iCascade;
            cnt        <= CntW'(WIDTH - 1);
            sticky     <= REC_NONE;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          aReg   <= aReg << 1;
          bReg   <= bReg << 1;
          cnt    <= cnt - 1'b1;
          sticky <= stickyNext;
          if ((EARLY_EXIT && diff) || cnt == '0) begin
            state <= DONE;
          end
        end
        DONE: begin
          oValid <= 1'b1;
          case (sticky)
            REC_GT:  oData <= CMP_GT;
            REC_LT:  oData <= CMP_LT;
            default: oData <= resolveEq(cascadeReg);
          endcase
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_compare_fsm.sv
// Drives an early-exit and a fixed-latency comparator with the same stimulus and
// checks every cycle against a timing/result model derived from operand values.
module tb_serial_compare_fsm;
  import cmp_pkg::*;

  localparam int W    = 8;
  localparam int LMAX = 128;

  logic         clk = 1'b0;
  logic         rstN;
  logic         iValid;
  logic [W-1:0] dA;
  logic [W-1:0] dB;
  logic [2:0]   casc;
  logic         oReady0, oValid0, oBusy0;
  logic         oReady1, oValid1, oBusy1;
  logic [2:0]   oData0, oData1;

  int passed = 0;
  int total  = 0;

  logic         vIn [LMAX];
  logic [W-1:0] aIn [LMAX];
  logic [W-1:0] bIn [LMAX];
  logic [2:0]   cIn [LMAX];
  logic         expV [2][LMAX];
  logic [2:0]   expD [2][LMAX];
  logic         expR [2][LMAX];
  logic [2:0]   lastD [2];

  always #5 clk = ~clk;

  serial_compare_fsm #(.WIDTH(W), .EARLY_EXIT(1'b1)) dutEarly (
    .iClk     (clk),
    .iRst_n   (rstN),
    .iValid   (iValid),
    .oReady   (oReady0),
    .iData_a  (dA),
    .iData_b  (dB),
    .iCascade (casc),
    .oValid   (oValid0),
    .oData    (oData0),
    .oBusy    (oBusy0)
  );

  serial_compare_fsm #(.WIDTH(W), .EARLY_EXIT(1'b0)) dutFixed (
    .iClk     (clk),
    .iRst_n   (rstN),
    .iValid   (iValid),
    .oReady   (oReady1),
    .iData_a  (dA),
    .iData_b  (dB),
    .iCascade (casc),
    .oValid   (oValid1),
    .oData    (oData1),
    .oBusy    (oBusy1)
  );

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: got %b expected %b", tag, obs, exp);
  endtask

  function automatic int bitsExamined(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input bit early);
    if (!early) return W;
    for (int i = W - 1; i >= 0; i--) begin
      if (a[i] != b[i]) return W - i;
    end
    return W;
  endfunction

  function automatic logic [2:0] refResult(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [2:0] c);
    if (a > b) return 3'b100;
    if (a < b) return 3'b010;
    if (c == 3'b100 || c == 3'b010 || c == 3'b001) return c;
    return 3'b000;
  endfunction

  // Accept when requested and free; result visible after edge k+n+1; free again at k+n+2.
  task automatic buildModel(input int len);
    for (int d = 0; d < 2; d++) begin
      int         freeAt;
      logic [2:0] cur;
      logic [2:0] resAt [LMAX];
      freeAt = 0;
      for (int k = 0; k < len; k++) begin
        expV[d][k] = 1'b0;
        expR[d][k] = 1'b1;
        resAt[k]   = 3'b000;
      end
      for (int k = 0; k < len; k++) begin
        if (vIn[k] && k >= freeAt) begin
          int n;
          n = bitsExamined(aIn[k], bIn[k], d == 0);
          for (int j = k; j <= k + n && j < len; j++) expR[d][j] = 1'b0;
          if (k + n + 1 < len) begin
            expV[d][k+n+1]  = 1'b1;
            resAt[k+n+1]    = refResult(aIn[k], bIn[k], cIn[k]);
          end
          freeAt = k + n + 2;
        end
      end
      cur = lastD[d];
      for (int k = 0; k < len; k++) begin
        if (expV[d][k]) cur = resAt[k];
        expD[d][k] = cur;
      end
      lastD[d] = cur;
    end
  endtask

  task automatic clearStim(input int len);
    for (int k = 0; k < len; k++) begin
      vIn[k] = 1'b0;
      aIn[k] = W'($urandom);
      bIn[k] = W'($urandom);
      cIn[k] = 3'($urandom);
    end
  endtask

  task automatic setTxn(input int k, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] c);
    vIn[k] = 1'b1;
    aIn[k] = a;
    bIn[k] = b;
    cIn[k] = c;
  endtask

  task automatic drive(input int k);
    iValid = vIn[k];
    dA     = aIn[k];
    dB     = bIn[k];
    casc   = cIn[k];
  endtask

  task automatic runPhase(input string name, input int len);
    buildModel(len);
    @(negedge clk);
    drive(0);
    for (int k = 0; k < len; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("%s k=%0d early oValid", name, k), {2'b0, oValid0}, {2'b0, expV[0][k]});
      check($sformatf("%s k=%0d early oData", name, k), oData0, expD[0][k]);
      check($sformatf("%s k=%0d early oReady", name, k), {2'b0, oReady0}, {2'b0, expR[0][k]});
      check($sformatf("%s k=%0d fixed oValid", name, k), {2'b0, oValid1}, {2'b0, expV[1][k]});
      check($sformatf("%s k=%0d fixed oData", name, k), oData1, expD[1][k]);
      check($sformatf("%s k=%0d fixed oReady", name, k), {2'b0, oReady1}, {2'b0, expR[1][k]});
      if (k + 1 < len) drive(k + 1);
      else iValid = 1'b0;
    end
  endtask

  task automatic checkIdleReset(input string name);
    check({name, " early oValid"}, {2'b0, oValid0}, 3'b000);
    check({name, " early oData"}, oData0, CMP_INV);
    check({name, " early oReady"}, {2'b0, oReady0}, 3'b001);
    check({name, " early oBusy"}, {2'b0, oBusy0}, 3'b000);
    check({name, " fixed oValid"}, {2'b0, oValid1}, 3'b000);
    check({name, " fixed oData"}, oData1, CMP_INV);
    check({name, " fixed oReady"}, {2'b0, oReady1}, 3'b001);
    check({name, " fixed oBusy"}, {2'b0, oBusy1}, 3'b000);
  endtask

  initial begin
    rstN   = 1'b0;
    iValid = 1'b0;
    dA     = '0;
    dB     = '0;
    casc   = 3'b001;
    lastD  = '{3'b000, 3'b000};
    #1;
    checkIdleReset("reset");
    repeat (2) @(negedge clk);
    rstN = 1'b1;

    // Directed pairs, spaced so each completes before the next request.
    clearStim(84);
    setTxn(0,  8'hA5, 8'h25, 3'b001);
    setTxn(12, 8'h3C, 8'h3D, 3'b001);
    setTxn(24, 8'h5A, 8'h5A, 3'b001);
    setTxn(36, 8'h5A, 8'h5A, 3'b100);
    setTxn(48, 8'h5A, 8'h5A, 3'b010);
    setTxn(60, 8'h5A, 8'h5A, 3'b011);
    setTxn(72, 8'h80, 8'h00, 3'b001);
    runPhase("directed", 84);

    // Abort mid-scan with an asynchronous reset.
    @(negedge clk);
    iValid = 1'b1;
    dA     = 8'hFF;
    dB     = 8'hFE;
    casc   = 3'b001;
    @(negedge clk);
    iValid = 1'b0;
    repeat (2) @(negedge clk);
    check("midscan early oBusy", {2'b0, oBusy0}, 3'b001);
    check("midscan fixed oBusy", {2'b0, oBusy1}, 3'b001);
    #2 rstN = 1'b0;
    #1;
    checkIdleReset("abort");
    @(negedge clk);
    rstN = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check($sformatf("postabort k=%0d early oValid", k), {2'b0, oValid0}, 3'b000);
      check($sformatf("postabort k=%0d fixed oValid", k), {2'b0, oValid1}, 3'b000);
    end
    lastD = '{3'b000, 3'b000};

    clearStim(12);
    setTxn(0, 8'h01, 8'h02, 3'b001);
    runPhase("afterabort", 12);

    // Request held high with operands changing every cycle.
    clearStim(52);
    for (int k = 0; k < 40; k++) begin
      logic [W-1:0] a;
      a = W'($urandom);
      case ($urandom_range(0, 2))
        0:       setTxn(k, a, a, 3'($urandom));
        1:       setTxn(k, a, a ^ W'(1 << $urandom_range(0, W - 1)), 3'b001);
        default: setTxn(k, a, W'($urandom), 3'b001);
      endcase
    end
    runPhase("backtoback", 52);

    // Sparse random requests.
    clearStim(72);
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        logic [W-1:0] a;
        a = W'($urandom);
        if ($urandom_range(0, 1) == 0) setTxn(k, a, a ^ W'(1 << $urandom_range(0, W - 1)),
                                              3'($urandom));
        else setTxn(k, a, a, 3'($urandom));
      end
    end
    runPhase("sparse", 72);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
